// File: rtl/instr_encoder.sv
// Instruction encoder: turns MIPS-like descriptors into 32-bit machine words,
// buffers them in a 2-entry FIFO with their byte address, and stops after
// 1024 words have been emitted.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  output logic [10:0] word_cnt,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] BaseAddr = 32'h0000_3000;
  localparam logic [10:0] Capacity = 11'd1024;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e      state_q;
  logic        live_q;
  logic [31:0] mem_addr_q  [2];
  logic [31:0] mem_instr_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] addr_q;
  logic [10:0] push_cnt_q, push_cnt_d;
  logic [10:0] word_cnt_q;
  logic        err_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept, push, pop;

  // Encode the descriptor; only the fields a format uses reach the word
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (in_mnem)
      5'd0:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      5'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      5'd2:  enc_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
      5'd3:  enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
      5'd4:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      5'd5:  enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
      5'd6:  enc_word = {6'h21, in_rs, in_rt, in_imm[15:0]};
      5'd7:  enc_word = {6'h20, in_rs, in_rt, in_imm[15:0]};
      5'd8:  enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
      5'd9:  enc_word = {6'h29, in_rs, in_rt, in_imm[15:0]};
      5'd10: enc_word = {6'h28, in_rs, in_rt, in_imm[15:0]};
      5'd11: enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
      5'd12: enc_word = {6'h05, in_rs, in_rt, in_imm[15:0]};
      5'd13: enc_word = {6'h03, in_imm};
      5'd14: enc_word = {6'h00, in_rs, 15'd0, 6'h08};
      5'd15: enc_word = {6'h02, in_imm};
      5'd16: enc_word = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
      default: enc_legal = 1'b0;
    endcase
  end

  // Handshakes, next occupancy and push count; clear masks in_ready so no push
  always_comb begin
    in_ready   = live_q & (state_q == StRun) & (occ_q != 2'd2) & ~clear;
    out_valid  = (occ_q != 2'd0);
    out_addr   = out_valid ? mem_addr_q[rd_ptr_q] : '0;
    out_instr  = out_valid ? mem_instr_q[rd_ptr_q] : '0;
    accept     = in_valid & in_ready;
    push       = accept & enc_legal;
    pop        = out_valid & out_ready;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    push_cnt_d = push_cnt_q + {10'd0, push};
  end

  assign word_cnt = word_cnt_q;
  assign done     = (state_q == StDone);
  assign err      = err_q;

  // FIFO storage, pointers, address/word counters and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q         <= 1'b0;
      mem_addr_q[0]  <= '0;
      mem_addr_q[1]  <= '0;
      mem_instr_q[0] <= '0;
      mem_instr_q[1] <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      occ_q          <= '0;
      addr_q         <= BaseAddr;
      push_cnt_q     <= '0;
      word_cnt_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (clear) begin
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        occ_q      <= '0;
        addr_q     <= BaseAddr;
        push_cnt_q <= '0;
        word_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        if (push) begin
          mem_addr_q[wr_ptr_q]  <= addr_q;
          mem_instr_q[wr_ptr_q] <= enc_word;
          wr_ptr_q              <= ~wr_ptr_q;
          addr_q                <= addr_q + 32'd4;
        end
        if (pop) begin
          rd_ptr_q   <= ~rd_ptr_q;
          word_cnt_q <= word_cnt_q + 11'd1;
        end
        if (accept && !enc_legal) err_q <= 1'b1;
        occ_q      <= occ_d;
        push_cnt_q <= push_cnt_d;
      end
    end
  end

  // Run until capacity is pushed, drain the FIFO, then park in done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
    end else if (clear) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:   if (push_cnt_d == Capacity) state_q <= StDrain;
        StDrain: if (occ_d == 2'd0) state_q <= StDone;
        StDone:  state_q <= StDone;
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and reset_n. reset_n assertion SHALL immediately clear all state; release SHALL be synchronous to clk.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port clear, input, 1 bit: synchronous flush of FIFO, address, counters and flags.
REQ-005 Port in_valid, input, 1 bit: descriptor valid.
REQ-006 Port in_ready, output, 1 bit: descriptor accepted when in_valid and in_ready are both 1.
REQ-007 Port in_mnem, input, 5 bits: 0 addu, 1 subu, 2 ori, 3 sll, 4 slt, 5 lw, 6 lh, 7 lb, 8 sw, 9 sh, 10 sb, 11 beq, 12 bne, 13 jal, 14 jr, 15 j, 16 lui; 17-31 illegal.
REQ-008 Ports in_rs, in_rt, in_rd and in_shamt, inputs, 5 bits each: register and shift fields.
REQ-009 Port in_imm, input, 26 bits: I-type uses [15:0]; J-type uses [25:0].
REQ-010 Port out_valid, output, 1 bit: the FIFO head is valid.
REQ-011 Port out_ready, input, 1 bit: instruction-memory sink ready.
REQ-012 Port out_addr, output, 32 bits: byte address of the head word.
REQ-013 Port out_instr, output, 32 bits: encoded machine word.
REQ-014 Port word_cnt, output, 11 bits: number of words emitted.
REQ-015 Port done, output, 1 bit: capacity reached.
REQ-016 Port err, output, 1 bit: sticky flag set on an illegal mnemonic.

Function
REQ-017 Encoding SHALL be:
- R-type (addu 0x21, subu 0x23, slt 0x2A): op 0 | rs | rt | rd | shamt 0 | funct.
- sll: op 0 | rs 0 | rt | rd | shamt | funct 0x00.
- jr: op 0 | rs | 15 zero bits | funct 0x08.
REQ-018 I-type encoding SHALL be op | rs | rt | imm[15:0], with ori 0x0D, lw 0x23, lh 0x21, lb 0x20, sw 0x2B, sh 0x29, sb 0x28, beq 0x04, bne 0x05, and lui 0x0F with rs forced to 0.
REQ-019 J-type encoding SHALL be op | imm[25:0], with j 0x02 and jal 0x03.
REQ-020 Any unused descriptor field SHALL be ignored and never leak into the encoded word.
REQ-021 The block SHALL contain a registered 2-entry FIFO of {addr, instr}; an accepted descriptor SHALL appear at the FIFO output no earlier than the next edge, giving a minimum latency of 1 cycle.
REQ-022 in_ready SHALL equal (FIFO occupancy < 2) & ~done & ~clear, and SHALL have no combinational path from out_ready.
REQ-023 Simultaneous push and pop at occupancy 1 SHALL keep occupancy at 1 and preserve order.
REQ-024 The address counter SHALL reset to 0x0000_3000 and advance by 4 per pushed word; out_addr SHALL be the address captured at push time.
REQ-025 An illegal mnemonic SHALL be consumed (handshake completes), SHALL set err, SHALL not be pushed and SHALL not advance the address.
REQ-026 word_cnt SHALL increment on each out_valid & out_ready.
REQ-027 FSM states SHALL be:
- RUN: accepting descriptors.
- DRAIN: 1024 words have been pushed; in_ready=0; the FIFO empties.
- DONE: FIFO empty and word_cnt = 1024; done=1.
REQ-028 The FSM SHALL transition RUN->DRAIN->DONE; only clear or reset SHALL return it to RUN.
REQ-029 clear SHALL have priority over a simultaneous push or pop, and the pending handshake SHALL be discarded.
REQ-030 out_valid/out_addr/out_instr SHALL hold stable while out_valid & ~out_ready.

Reset
REQ-031 On reset_n=0, outputs SHALL be: out_valid=0, out_addr=0, out_instr=0, word_cnt=0, done=0, err=0, in_ready=0, with FIFO occupancy 0, the address counter at 0x3000 and the FSM in RUN.
REQ-032 Reset asserted mid-handshake or mid-drain SHALL drop all buffered words.
REQ-033 in_ready SHALL go to 1 on the first edge after reset_n=1.

Verification
REQ-034 Encode check: addu rs=1 rt=2 rd=3 -> 0x00221821 @0x3000; ori rs=0 rt=1 imm=0x1234 -> 0x34011234 @0x3004; lui rt=5 imm=0xFFFF with rs=7 -> 0x3C05FFFF; jal imm=0x0000C00 -> 0x0C000C00; sll rt=2 rd=4 shamt=3 -> 0x00022 0C0.
REQ-035 Backpressure: out_ready=0 with 3 descriptors offered -> 2 accepted, in_ready=0, head stable at 0x3000; then out_ready=1 -> words drain in order.
REQ-036 Illegal: in_mnem=20 -> err=1, no push, next legal word lands at 0x3000.
REQ-037 Capacity: 1025 descriptors -> 1024 emitted, last address 0x3FFC, done=1, in_ready=0, word_cnt=1024.
REQ-038 Reset/clear mid-stream: reset_n pulsed low with 2 words buffered -> out_valid=0 immediately; next word lands at 0x3000.
